multi_gate_pipe: RTL and testbench

- Parametrised, registered successor to the team's two-input single-bit gate primitives.
- Applies a runtime-selected bitwise logic function across NUM_IN lanes of WIDTH bits.
- Results leave through a valid/ready stream backed by a 2-entry output buffer.
- Used as a configurable logic stage between streaming blocks; replaces per-gate instances in datapaths.

---
 rtl/multi_gate_pkg.sv | 59 +++++
 rtl/multi_gate_buf2.sv | 89 ++++++++
 rtl/multi_gate_pipe.sv | 81 ++++++++
 tb/tb_multi_gate_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_gate_pkg.sv
// Shared definitions for multi_gate_pipe: function codes, lane-wise gate
// evaluation and parity helper.
package multi_gate_pkg;

  localparam int GATE_MAX_W  = 64;
  localparam int GATE_MAX_IN = 8;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_NOT  = 3'd6,
    MODE_PASS = 3'd7
  } gate_mode_e;

  typedef logic [GATE_MAX_IN-1:0][GATE_MAX_W-1:0] gate_lanes_t;

  // Bits above 'width' are forced to zero so parity over the full word equals lane parity.
  function automatic logic [GATE_MAX_W-1:0] gate_apply(input logic [2:0] mode,
                                                       input gate_lanes_t lanes,
                                                       input int num_in,
                                                       input int width);
    logic [GATE_MAX_W-1:0] acc_and;
    logic [GATE_MAX_W-1:0] acc_or;
    logic [GATE_MAX_W-1:0] acc_xor;
    logic [GATE_MAX_W-1:0] res;
    logic [GATE_MAX_W-1:0] mask;
    acc_and = {GATE_MAX_W{1'b1}};
    acc_or  = {GATE_MAX_W{1'b0}};
    acc_xor = {GATE_MAX_W{1'b0}};
    for (int i = 0; i < num_in; i++) begin
      acc_and = acc_and & lanes[i];
      acc_or  = acc_or  | lanes[i];
      acc_xor = acc_xor ^ lanes[i];
    end
    case (gate_mode_e'(mode))
      MODE_AND:  res = acc_and;
      MODE_OR:   res = acc_or;
      MODE_XOR:  res = acc_xor;
      MODE_NAND: res = ~acc_and;
      MODE_NOR:  res = ~acc_or;
      MODE_XNOR: res = ~acc_xor;
      MODE_NOT:  res = ~lanes[0];
      MODE_PASS: res = lanes[0];
      default:   res = {GATE_MAX_W{1'b0}};
    endcase
    mask = {GATE_MAX_W{1'b1}} >> (GATE_MAX_W - width);
    return res & mask;
  endfunction

  function automatic logic parity_of(input logic [GATE_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/multi_gate_buf2.sv
// Two-entry in-order valid/ready buffer; slot 0 is always the head so the
// output word comes straight from a register.
module multi_gate_buf2
  import multi_gate_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] s0_q, s0_d;
  logic [W-1:0] s1_q, s1_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         push_s, pop_s;

  assign push_s = in_valid_i & ready_q;
  assign pop_s  = valid_q & out_ready_i;

  // Occupancy update; a push with a pop at occupancy 1 refills the head directly.
  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    case (cnt_q)
      2'd0: begin
        if (push_s) begin
          s0_d  = in_data_i;
          cnt_d = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          s0_d = in_data_i;
        end else if (push_s) begin
          s1_d  = in_data_i;
          cnt_d = 2'd2;
        end else if (pop_s) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          s0_d  = s1_q;
          cnt_d = 2'd1;
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    valid_d = (cnt_d != 2'd0);
    ready_d = (cnt_d < FIFO_DEPTH);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      s0_q    <= {W{1'b0}};
      s1_q    <= {W{1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = s0_q;

endmodule

// File: rtl/multi_gate_pipe.sv
// Runtime-selectable bitwise gate across NUM_IN lanes with a 2-entry output
// buffer. Define MULTI_GATE_XFER_CNT_EN to add the saturating xfer_count port.
module multi_gate_pipe
  import multi_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_parity
`ifdef MULTI_GATE_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0]        xfer_count
`endif
);

  gate_lanes_t            lanes_s;
  logic [GATE_MAX_W-1:0]  gate_full_s;
  logic [WIDTH:0]         buf_in_s;
  logic [WIDTH:0]         buf_out_s;

  // Spread the packed lanes into the fixed-size form the gate helper expects.
  always_comb begin
    lanes_s = {(GATE_MAX_IN*GATE_MAX_W){1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      lanes_s[i][WIDTH-1:0] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign gate_full_s = gate_apply(in_mode, lanes_s, NUM_IN, WIDTH);
  assign buf_in_s    = {parity_of(gate_full_s), gate_full_s[WIDTH-1:0]};

  multi_gate_buf2 #(.W(WIDTH + 1)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (buf_in_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out_s)
  );

  assign out_data   = buf_out_s[WIDTH-1:0];
  assign out_parity = buf_out_s[WIDTH];

`ifdef MULTI_GATE_XFER_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Count output transfers, holding at all-ones instead of wrapping.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid && out_ready && (xfer_cnt_q != {CNT_W{1'b1}})) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1'b1);
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= {CNT_W{1'b0}};
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Bench for multi_gate_pipe (WIDTH=8, NUM_IN=3): directed cases plus random
// traffic checked against a queue-based reference of the output buffer.
module tb_multi_gate_pipe;

  localparam int TW = 8;
  localparam int TN = 3;
  localparam int TC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TN*TW-1:0] in_data;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          out_parity;
`ifdef MULTI_GATE_XFER_CNT_EN
  logic [TC-1:0] xfer_count;
  int            cnt_m = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW:0]   mq[$];     // expected buffer contents {parity, data}, head first
  logic [TW-1:0] got_q[$];  // values observed leaving the DUT

  multi_gate_pipe #(.WIDTH(TW), .NUM_IN(TN), .CNT_W(TC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity)
`ifdef MULTI_GATE_XFER_CNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-bit reference: count how many lanes carry a one and decide from the count.
  function automatic logic [TW:0] model_result(input logic [2:0] mode, input logic [TN*TW-1:0] d);
    logic [TW-1:0] r;
    int ones;
    int par;
    par = 0;
    for (int b = 0; b < TW; b++) begin
      ones = 0;
      for (int l = 0; l < TN; l++) ones += int'(d[l*TW + b]);
      case (mode)
        3'd0: r[b] = (ones == TN);
        3'd1: r[b] = (ones != 0);
        3'd2: r[b] = (ones % 2 == 1);
        3'd3: r[b] = (ones != TN);
        3'd4: r[b] = (ones == 0);
        3'd5: r[b] = (ones % 2 == 0);
        3'd6: r[b] = ~d[b];
        default: r[b] = d[b];
      endcase
      par += int'(r[b]);
    end
    return {(par % 2 == 1), r};
  endfunction

  // One clock: predict transfers from the model, advance, then compare.
  task automatic step();
    bit push, pop;
    logic [TW:0] nr;
    push = !rst && in_valid && (mq.size() < 2);
    pop  = !rst && out_ready && (mq.size() > 0);
    nr   = model_result(in_mode, in_data);
    if (pop) got_q.push_back(out_data);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(nr);
    end
`ifdef MULTI_GATE_XFER_CNT_EN
    if (rst) cnt_m = 0;
    else if (pop && cnt_m < (2**TC - 1)) cnt_m++;
    check_eq("xfer_count", xfer_count, cnt_m);
`endif
    check_eq("in_ready", in_ready, mq.size() < 2);
    check_eq("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check_eq("out_data", out_data, mq[0][TW-1:0]);
      check_eq("out_parity", out_parity, mq[0][TW]);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [TN*TW-1:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
  endtask

  logic [TW-1:0] modes_exp [8] = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69, 8'h0F, 8'hF0};
  logic [TW-1:0] bp_exp [3]    = '{8'h0F, 8'h03, 8'hAA};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit accepted;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 24'h0);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_parity", out_parity, 1'b0);

    // NOR of 0x0F and 0x30 (third lane zero leaves NOR unchanged).
    out_ready = 1'b1;
    drive(1'b1, 3'd4, {8'h00, 8'h30, 8'h0F});
    step();
    drive(1'b0, 3'd0, 24'h0);
    check_eq("nor_valid", out_valid, 1'b1);
    check_eq("nor_data", out_data, 8'hC0);
    check_eq("nor_parity", out_parity, 1'b0);
    step();

    // All eight modes back-to-back on lanes F0/CC/AA.
    got_q.delete();
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 3'(m), {8'hAA, 8'hCC, 8'hF0});
      step();
    end
    drive(1'b0, 3'd0, 24'h0);
    step();
    check_eq("modes_count", got_q.size(), 8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) check_eq("modes_data", got_q[k], modes_exp[k]);

    // Backpressure: two beats fill the buffer, the third must wait.
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, {8'hFF, 8'h0F, 8'hFF});
    step();
    drive(1'b1, 3'd1, {8'h00, 8'h02, 8'h01});
    step();
    check_eq("bp_full_ready", in_ready, 1'b0);
    drive(1'b1, 3'd2, {8'h00, 8'hFF, 8'h55});
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_stall_data", out_data, 8'h0F);
    end
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 6 && !accepted; i++) begin
      accepted = (mq.size() < 2);
      step();
    end
    check_eq("bp_third_accepted", accepted, 1'b1);
    drive(1'b0, 3'd0, 24'h0);
    for (int i = 0; i < 4; i++) step();
    check_eq("bp_count", got_q.size(), 3);
    for (int k = 0; k < 3 && k < got_q.size(); k++) check_eq("bp_data", got_q[k], bp_exp[k]);

    // Continuous streaming: one result per cycle, in_ready stays high.
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 24'($urandom()));
      step();
    end
    drive(1'b0, 3'd0, 24'h0);
    step();
    check_eq("stream_count", got_q.size(), 40);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom()));
      step();
    end
    rst = 1'b0;

    // Reset while full, with a beat offered in the reset cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 24'($urandom()));
      step();
    end
    check_eq("mid_full_ready", in_ready, 1'b0);
    rst = 1'b1;
    drive(1'b1, 3'd7, 24'h0000FF);
    step();
    rst = 1'b0;
    drive(1'b0, 3'd0, 24'h0);
    out_ready = 1'b1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_ready", in_ready, 1'b1);
    got_q.delete();
    for (int i = 0; i < 3; i++) step();
    check_eq("mid_rst_no_stale", got_q.size(), 0);
    check_eq("mid_rst_data", out_data, 8'h00);

`ifdef MULTI_GATE_XFER_CNT_EN
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 24'($urandom()));
      step();
    end
    drive(1'b0, 3'd0, 24'h0);
    step();
    check_eq("cnt_saturated", xfer_count, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("cnt_cleared", xfer_count, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
